// File: rtl/ex_pkg.sv
// Purpose : shared types and constants for the execute stage (forward selects, ALU op codes, ID/EX record).
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// The ID/EX record is sized by EX_DW/EX_RW. The ex_stage DW/RW parameters must
// match these values, because the packed struct cannot follow module parameters.
package ex_pkg;

   localparam int EX_DW = 32;
   localparam int EX_RW = 5;

   // Forwarding mux selects; 2'b11 is not a named member and falls back to FWD_RF.
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   // alucontrol[2] inverts b and injects the carry. alucontrol[1:0] selects the result.
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic             regwrite;
      logic             memtoreg;
      logic             memwrite;
      logic             alusrc;
      logic             regdst;
      logic [2:0]       alucontrol;
      logic [EX_DW-1:0] rd1;
      logic [EX_DW-1:0] rd2;
      logic [EX_DW-1:0] signimm;
      logic [EX_RW-1:0] rs;
      logic [EX_RW-1:0] rt;
      logic [EX_RW-1:0] rd;
   } id_ex_t;

   // The bubble image is the reset image. It writes nothing and performs AND of zeros.
   localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/alu.sv
// Purpose : MIPS ALU (AND/OR/add/sub/slt) on two DW-bit operands.
// Latency : combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports: a, b (operands), alucontrol (3-bit op), y (result).
// Carry and overflow are discarded. slt is the sign bit of the wrapped a-b, with no overflow correction.
module alu #(
   parameter int DW = 32
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [2:0]    alucontrol,
   output logic [DW-1:0] y
);

   logic          inv;
   logic [DW-1:0] bb;
   logic [DW-1:0] sum;

   assign inv = alucontrol[2];
   assign bb  = inv ? ~b : b;
   assign sum = a + bb + {{(DW-1){1'b0}}, inv};

   // AND and OR use the true b. Codes 100 and 101 therefore behave like 000 and 001.
   always_comb begin
      y = '0;
      case (alucontrol[1:0])
         2'b00:   y = a & b;
         2'b01:   y = a | b;
         2'b10:   y = sum;
         default: y = {{(DW-1){1'b0}}, sum[DW-1]};
      endcase
   end

endmodule

// File: rtl/ex_stage_id_ex_reg.sv
// Purpose : ID/EX pipeline register with flush (bubble) and stall (hold).
// Latency : one core clock edge from d to q.
// Backpressure: stall holds every field. Flush overrides stall and loads the zero bubble.
//
// Ports: clk, reset (async active-low), stall, flush, d (decode record), q (registered record).
// Priority per edge is flush > stall > load. Reset clears asynchronously and wins over everything.
module id_ex_reg
   import ex_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   stall,
   input  logic   flush,
   input  id_ex_t d,
   output id_ex_t q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= ID_EX_BUBBLE;
      end else if (flush) begin
         q <= ID_EX_BUBBLE;
      end else if (!stall) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Purpose : MIPS execute stage: ID/EX register, operand forwarding, ALUSrc/RegDst muxes, ALU.
// Latency : decode inputs reach the EX outputs one edge later. Forwarding inputs act combinationally.
// Backpressure: stall_e freezes the ID/EX register. flush_e inserts a NOP bubble and has priority over stall_e.
//
// Ports: clk, reset (async active-low); stall_e/flush_e from the hazard unit;
//        rd1_d/rd2_d/signimm_d/rs_d/rt_d/rd_d and decode controls in;
//        forward_ae/forward_be with aluout_m/result_w as forwarding sources;
//        registered controls, rs_e/rt_e, writereg_e, aluout_e and writedata_e out.
// Build option: define EX_STAGE_FWD_EN to enable the forwarding muxes. When it is not defined,
//               the forwarding ports are present but ignored, and the core must resolve hazards with stalls.
module ex_stage
   import ex_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall_e,
   input  logic          flush_e,
   input  logic [DW-1:0] rd1_d,
   input  logic [DW-1:0] rd2_d,
   input  logic [DW-1:0] signimm_d,
   input  logic [RW-1:0] rs_d,
   input  logic [RW-1:0] rt_d,
   input  logic [RW-1:0] rd_d,
   input  logic          regwrite_d,
   input  logic          memtoreg_d,
   input  logic          memwrite_d,
   input  logic          alusrc_d,
   input  logic          regdst_d,
   input  logic [2:0]    alucontrol_d,
   input  logic [1:0]    forward_ae,
   input  logic [1:0]    forward_be,
   input  logic [DW-1:0] aluout_m,
   input  logic [DW-1:0] result_w,
   output logic          regwrite_e,
   output logic          memtoreg_e,
   output logic          memwrite_e,
   output logic [RW-1:0] rs_e,
   output logic [RW-1:0] rt_e,
   output logic [RW-1:0] writereg_e,
   output logic [DW-1:0] aluout_e,
   output logic [DW-1:0] writedata_e
);

   id_ex_t        d;
   id_ex_t        q;
   logic [DW-1:0] srca;
   logic [DW-1:0] fwdb;
   logic [DW-1:0] srcb;

   assign d.regwrite   = regwrite_d;
   assign d.memtoreg   = memtoreg_d;
   assign d.memwrite   = memwrite_d;
   assign d.alusrc     = alusrc_d;
   assign d.regdst     = regdst_d;
   assign d.alucontrol = alucontrol_d;
   assign d.rd1        = rd1_d;
   assign d.rd2        = rd2_d;
   assign d.signimm    = signimm_d;
   assign d.rs         = rs_d;
   assign d.rt         = rt_d;
   assign d.rd         = rd_d;

   id_ex_reg u_id_ex_reg (
      .clk   (clk),
      .reset (reset),
      .stall (stall_e),
      .flush (flush_e),
      .d     (d),
      .q     (q)
   );

`ifdef EX_STAGE_FWD_EN
   // MEM is the younger producer, but the hazard unit resolves priority. This block only decodes the select.
   always_comb begin
      srca = q.rd1;
      case (forward_ae)
         FWD_WB:  srca = result_w;
         FWD_MEM: srca = aluout_m;
         default: srca = q.rd1;
      endcase
   end

   always_comb begin
      fwdb = q.rd2;
      case (forward_be)
         FWD_WB:  fwdb = result_w;
         FWD_MEM: fwdb = aluout_m;
         default: fwdb = q.rd2;
      endcase
   end
`else
   logic unused_fwd;

   assign unused_fwd = ^{forward_ae, forward_be, aluout_m, result_w};
   assign srca       = q.rd1;
   assign fwdb       = q.rd2;
`endif

   // Store data is always the forwarded rt value, never the immediate.
   assign srcb        = q.alusrc ? q.signimm : fwdb;
   assign writedata_e = fwdb;
   assign writereg_e  = q.regdst ? q.rd : q.rt;

   assign regwrite_e = q.regwrite;
   assign memtoreg_e = q.memtoreg;
   assign memwrite_e = q.memwrite;
   assign rs_e       = q.rs;
   assign rt_e       = q.rt;

   alu #(.DW(DW)) u_alu (
      .a          (srca),
      .b          (srcb),
      .alucontrol (q.alucontrol),
      .y          (aluout_e)
   );

endmodule

// File: tb/tb_ex_stage.sv
// Purpose : directed, table-driven check of ex_stage, plus reset/stall/flush sequences.
// Latency : outputs are sampled 1 time unit after the loading edge.
// Backpressure: exercises stall_e, flush_e and their combination.
module tb_ex_stage;
   import ex_pkg::*;

`ifdef EX_STAGE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, stall_e, flush_e;
   logic [31:0] rd1_d, rd2_d, signimm_d, aluout_m, result_w;
   logic [4:0]  rs_d, rt_d, rd_d;
   logic        regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
   logic [2:0]  alucontrol_d;
   logic [1:0]  forward_ae, forward_be;
   logic        regwrite_e, memtoreg_e, memwrite_e;
   logic [4:0]  rs_e, rt_e, writereg_e;
   logic [31:0] aluout_e, writedata_e;

   always #5 clk = ~clk;

   ex_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
      .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
      .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
      .alusrc_d(alusrc_d), .regdst_d(regdst_d), .alucontrol_d(alucontrol_d),
      .forward_ae(forward_ae), .forward_be(forward_be),
      .aluout_m(aluout_m), .result_w(result_w),
      .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
      .rs_e(rs_e), .rt_e(rt_e), .writereg_e(writereg_e),
      .aluout_e(aluout_e), .writedata_e(writedata_e)
   );

   typedef struct packed {
      logic [31:0] aluout;
      logic [31:0] wd;
      logic [4:0]  wr;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        rw;
      logic        m2r;
      logic        mw;
   } exp_t;

   typedef struct {
      logic [2:0]  op;
      logic        asrc, rdst;
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
      logic        rw, m2r, mw;
      logic [1:0]  fa, fb;
      logic [31:0] am, rwv;
      exp_t        e;
   } vec_t;

   int   nvec  = 0;
   int   nfail = 0;
   vec_t vt[18];
   exp_t zero_e;

   function automatic vec_t mk(input logic [2:0] op, input logic asrc, input logic rdst,
                               input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic rw, input logic m2r, input logic mw,
                               input logic [1:0] fa, input logic [1:0] fb,
                               input logic [31:0] am, input logic [31:0] rwv,
                               input logic [31:0] ealu, input logic [31:0] ewd, input logic [4:0] ewr);
      vec_t v;
      v.op = op; v.asrc = asrc; v.rdst = rdst;
      v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
      v.rs = rs; v.rt = rt; v.rd = rd;
      v.rw = rw; v.m2r = m2r; v.mw = mw;
      v.fa = fa; v.fb = fb; v.am = am; v.rwv = rwv;
      v.e.aluout = ealu; v.e.wd = ewd; v.e.wr = ewr;
      v.e.rs = rs; v.e.rt = rt; v.e.rw = rw; v.e.m2r = m2r; v.e.mw = mw;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      alucontrol_d = v.op; alusrc_d = v.asrc; regdst_d = v.rdst;
      rd1_d = v.rd1; rd2_d = v.rd2; signimm_d = v.imm;
      rs_d = v.rs; rt_d = v.rt; rd_d = v.rd;
      regwrite_d = v.rw; memtoreg_d = v.m2r; memwrite_d = v.mw;
      forward_ae = v.fa; forward_be = v.fb; aluout_m = v.am; result_w = v.rwv;
   endtask

   task automatic check(input string nm, input exp_t e);
      exp_t a;
      a.aluout = aluout_e; a.wd = writedata_e; a.wr = writereg_e;
      a.rs = rs_e; a.rt = rt_e; a.rw = regwrite_e; a.m2r = memtoreg_e; a.mw = memwrite_e;
      nvec++;
      if (a !== e) begin
         nfail++;
         $display("FAIL %s: got alu=%h wd=%h wr=%0d rs=%0d rt=%0d rw/m2r/mw=%b%b%b, want alu=%h wd=%h wr=%0d rs=%0d rt=%0d rw/m2r/mw=%b%b%b",
                  nm, a.aluout, a.wd, a.wr, a.rs, a.rt, a.rw, a.m2r, a.mw,
                  e.aluout, e.wd, e.wr, e.rs, e.rt, e.rw, e.m2r, e.mw);
      end
   endtask

   task automatic step_check(input string nm, input exp_t e);
      @(posedge clk);
      #1;
      check(nm, e);
   endtask

   initial begin
      zero_e = '0;
      //      op       as rd  rd1           rd2           imm           rs  rt  rd  rw m2r mw fa     fb     am            rwv           alu                           wd                            wr
      vt[0]  = mk(ALU_SUB, 0, 1, 32'd5,        32'd3,        32'd0,        1,  2,  3,  1, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'd2,                         32'd3,                         3);
      vt[1]  = mk(ALU_SLT, 0, 0, 32'd3,        32'd5,        32'd0,        4,  9,  17, 1, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'd1,                         32'd5,                         9);
      vt[2]  = mk(ALU_ADD, 0, 1, 32'hFFFFFFFF, 32'd1,        32'd0,        6,  7,  8,  1, 1, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'd0,                         32'd1,                         8);
      vt[3]  = mk(ALU_ADD, 1, 1, 32'd8,        32'h55,       32'hFFFFFFFC, 10, 9,  17, 1, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'd4,                         32'h55,                        17);
      vt[4]  = mk(ALU_AND, 0, 0, 32'hF0F0,     32'hFF00,     32'd0,        11, 12, 13, 1, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'hF000,                      32'hFF00,                      12);
      vt[5]  = mk(ALU_OR,  0, 0, 32'hF0F0,     32'hFF00,     32'd0,        14, 15, 16, 0, 0, 1, 2'b00, 2'b00, 32'h0,        32'h0,        32'hFFF0,                      32'hFF00,                      15);
      vt[6]  = mk(3'b100,  0, 1, 32'hF0F0,     32'hFF00,     32'd0,        18, 19, 20, 1, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'hF000,                      32'hFF00,                      20);
      vt[7]  = mk(3'b101,  0, 1, 32'hF0F0,     32'hFF00,     32'd0,        21, 22, 23, 1, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'hFFF0,                      32'hFF00,                      23);
      vt[8]  = mk(ALU_SLT, 0, 0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0,        24, 25, 26, 1, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'd1,                         32'hFFFFFFFF,                  25);
      vt[9]  = mk(ALU_SLT, 0, 0, 32'd5,        32'd3,        32'd0,        27, 28, 29, 1, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'd0,                         32'd3,                         28);
      vt[10] = mk(ALU_ADD, 0, 1, 32'h12345678, 32'h11111111, 32'd0,        30, 31, 1,  1, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'h23456789,                  32'h11111111,                  1);
      vt[11] = mk(ALU_SUB, 0, 1, 32'd3,        32'd5,        32'd0,        2,  3,  4,  1, 0, 0, 2'b00, 2'b00, 32'h0,        32'h0,        32'hFFFFFFFE,                  32'd5,                         4);
      vt[12] = mk(ALU_ADD, 1, 0, 32'd1,        32'd2,        32'd0,        1,  2,  3,  1, 0, 0, 2'b10, 2'b00, 32'h100,      32'h20,       FWD ? 32'h100 : 32'h1,         32'd2,                         2);
      vt[13] = mk(ALU_ADD, 1, 0, 32'd1,        32'd2,        32'd0,        1,  2,  3,  1, 0, 0, 2'b01, 2'b00, 32'h100,      32'h20,       FWD ? 32'h20 : 32'h1,          32'd2,                         2);
      vt[14] = mk(ALU_ADD, 1, 0, 32'd1,        32'd2,        32'd0,        1,  2,  3,  1, 0, 0, 2'b11, 2'b00, 32'h100,      32'h20,       32'h1,                         32'd2,                         2);
      vt[15] = mk(ALU_ADD, 0, 0, 32'd1,        32'd2,        32'd0,        1,  2,  3,  0, 0, 1, 2'b00, 2'b10, 32'h100,      32'h20,       FWD ? 32'h101 : 32'h3,         FWD ? 32'h100 : 32'h2,         2);
      vt[16] = mk(ALU_ADD, 0, 0, 32'd1,        32'd2,        32'd0,        1,  2,  3,  0, 0, 1, 2'b00, 2'b01, 32'h100,      32'h20,       FWD ? 32'h21 : 32'h3,          FWD ? 32'h20 : 32'h2,          2);
      vt[17] = mk(ALU_SUB, 0, 0, 32'd1,        32'd2,        32'd0,        1,  2,  3,  0, 0, 1, 2'b10, 2'b10, 32'h100,      32'h20,       FWD ? 32'h0 : 32'hFFFFFFFF,    FWD ? 32'h100 : 32'h2,         2);

      // Hold reset low with non-zero decode inputs. Forwarding selects stay at 00.
      reset = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
      drive(vt[10]);
      repeat (2) @(posedge clk);
      #1 check("reset_hold", zero_e);
      @(negedge clk) reset = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk) drive(vt[i]);
         step_check($sformatf("vec%0d", i), vt[i].e);
      end

      // An asynchronous reset pulse between edges clears the outputs without a clock edge.
      @(negedge clk) drive(vt[0]);
      step_check("pre_pulse", vt[0].e);
      #2 reset = 1'b0;
      #1 check("async_clear", zero_e);
      reset = 1'b1;
      step_check("release_reload", vt[0].e);

      // Stall for three cycles while the decode inputs change.
      @(negedge clk) drive(vt[3]);
      step_check("stall_load", vt[3].e);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk) begin drive(vt[4 + k]); stall_e = 1'b1; end
         step_check($sformatf("stall_hold%0d", k), vt[3].e);
      end
      @(negedge clk) begin stall_e = 1'b0; drive(vt[1]); end
      step_check("stall_release", vt[1].e);

      // Flush has priority over stall on the same edge.
      @(negedge clk) begin stall_e = 1'b1; flush_e = 1'b1; drive(vt[2]); end
      step_check("stall_flush", zero_e);
      @(negedge clk) begin stall_e = 1'b0; flush_e = 1'b0; drive(vt[0]); end
      step_check("post_flush_load", vt[0].e);
      @(negedge clk) flush_e = 1'b1;
      step_check("flush_only", zero_e);
      @(negedge clk) flush_e = 1'b0;
      step_check("flush_release", vt[0].e);

      // Reset during a stall clears at once. After release, the stall still holds the bubble.
      @(negedge clk) stall_e = 1'b1;
      #1 reset = 1'b0;
      #1 check("reset_in_stall", zero_e);
      reset = 1'b1;
      step_check("stall_after_reset", zero_e);
      @(negedge clk) stall_e = 1'b0;
      step_check("resume_after_reset", vt[0].e);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage pipelined MIPS core: ID/EX pipeline register, operand forwarding muxes, ALUSrc/RegDst selection and the existing alu datapath.
Consumes decode-stage operands and control; produces EX-stage ALU result, store data and destination register for the EX/MEM register.
Exports rs_e/rt_e to the hazard unit and accepts its stall/flush/forward controls.

Parameters:
DW, 32, datapath width
RW, 5, register-index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
stall_e  in  1  hold ID/EX register contents
flush_e  in  1  load bubble into ID/EX register
rd1_d  in  DW  register-file read A
rd2_d  in  DW  register-file read B
signimm_d  in  DW  sign-extended immediate
rs_d, rt_d, rd_d  in  RW each  instruction register fields
regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d  in  1 each  decode control
alucontrol_d  in  3  ALU op
forward_ae, forward_be  in  2 each  forwarding selects
aluout_m  in  DW  MEM-stage ALU result
result_w  in  DW  WB-stage result
regwrite_e, memtoreg_e, memwrite_e  out  1 each  registered control to EX/MEM
rs_e, rt_e  out  RW each  registered fields for hazard unit
writereg_e  out  RW  destination register
aluout_e  out  DW  ALU result
writedata_e  out  DW  forwarded store data (forwarded rt)

Behaviour:
- ID/EX register holds all *_d inputs and updates on posedge clk.
- Async reset (reset=0): every register clears to 0 immediately. All outputs are then 0: control bits, rs_e/rt_e/writereg_e, and aluout_e = 0 & 0 (AND op) = 0.
- Priority per edge: flush_e > stall_e > load.
  - flush_e=1: register cleared to 0, identical to the reset image (a NOP bubble, regwrite_e=memwrite_e=0).
  - stall_e=1 with flush_e=0: all fields hold.
- Reset asserted mid-stall or mid-flush wins immediately. Release is synchronous to the next edge with normal priority.
- Forward select (each operand): 00 = registered rd1/rd2; 01 = result_w; 10 = aluout_m; 11 = treated as 00.
- srca = fwdA. writedata_e = fwdB. srcb = alusrc_e ? signimm_e : fwdB.
- writereg_e = regdst_e ? rd_e : rt_e.
- ALU, alucontrol[2] = invert: b' = inv ? ~srcb : srcb; sum = srca + b' + inv (mod 2^DW, carry/overflow discarded).
- ALU, alucontrol[1:0]: 00 AND (uses true srcb), 01 OR (true srcb), 10 sum, 11 slt = {DW-1 zeros, sum[DW-1]}.
  - Codes 000/001 give AND/OR.
  - 100/101 also give plain AND/OR because b' is ignored.
  - slt uses the sign of the wrapped difference with no overflow correction. Example: 0x7FFFFFFF slt 0xFFFFFFFF gives 1.
- Latency: decode inputs appear at EX outputs one edge later. Forwarding inputs affect aluout_e/writedata_e combinationally in the same cycle.

Optional Feature:
EX_STAGE_FWD_EN
- Defined: forwarding muxes operate as above.
- Undefined: forward_ae/forward_be/aluout_m/result_w are ignored and srca/fwdB come from registered rd1/rd2. The ports remain present; the core must then rely on stalls.

Decomposition:
- Package ex_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - ALU op localparams: ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - id_ex_t packed struct: all registered fields.
- One natural sub-module, id_ex_reg, containing the flush/stall/reset register of id_ex_t.
- The existing alu module is instantiated unchanged for the arithmetic.

Test Plan:
- Reset: reset=0 with arbitrary inputs -> all outputs 0. Hold reset=1 then pulse 0 between edges -> outputs clear without a clock edge.
- Add/sub/slt:
  - rd1_d=5, rd2_d=3, ALU_SUB, alusrc=0 -> next cycle aluout_e=2.
  - ALU_SLT with rd1=3, rd2=5 -> 1.
  - 0xFFFFFFFF+1 with ALU_ADD -> 0.
- Immediate/regdst: alusrc=1, signimm=0xFFFFFFFC, rd1=8, ALU_ADD -> aluout_e=4. regdst=1, rd_d=17, rt_d=9 -> writereg_e=17; regdst=0 -> 9.
- Forwarding (EX_STAGE_FWD_EN), with rd1=1, aluout_m=0x100, result_w=0x20:
  - forward_ae=10 -> srca=0x100.
  - forward_ae=01 -> srca=0x20.
  - forward_ae=11 -> srca=1.
  - forward_be=10 with memwrite -> writedata_e=aluout_m.
- Stall/flush:
  - stall_e=1 for 3 cycles while inputs change -> outputs frozen.
  - stall_e=1 and flush_e=1 on the same edge -> all-zero bubble, regwrite_e=0.
- Without EX_STAGE_FWD_EN: forward_ae=10, aluout_m=0x100, rd1=1 -> srca=1.
